// File: rtl/mem_pkg.sv
// Shared types, funct3 codes and access checks for the memory-stage LSU.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Halfwords need an even address, words a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only have signed-size codes; loads add the unsigned variants.
   function automatic logic is_legal(input logic [2:0] funct3, input logic store);
      logic ok;
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      if (!store)
         ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and byte/half extraction with extension for loads.
module mem_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [31:0] shifted;

   // Move the addressed byte/half down to bit 0, then extend per access type.
   always_comb begin
      shifted = bus_rdata >> {addr_lo, 3'b000};
      wstrb   = 4'b0000;
      wdata   = rs2;
      ldata   = shifted;
      case (funct3)
         F3_B: begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{rs2[7:0]}};
            ldata = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            wstrb = 4'b0011 << addr_lo;
            wdata = {2{rs2[15:0]}};
            ldata = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_W: begin
            wstrb = 4'b1111;
            wdata = rs2;
            ldata = bus_rdata;
         end
         F3_BU:   ldata = {24'd0, shifted[7:0]};
         F3_HU:   ldata = {16'd0, shifted[15:0]};
         default: ldata = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one req/gnt + rvalid bus transaction per op,
// stalling upstream until the op completes.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit BUS_ERR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic            op_store,
   input  logic [2:0]      op_funct3,
   input  logic [XLEN-1:0] op_addr,
   input  logic [XLEN-1:0] op_wdata,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] rdata,
   output logic            fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_wstrb,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_err
);

   lsu_state_t  state, state_nx;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_ldata;
   logic        accept;
   logic        bad;

   assign accept = (state == IDLE) && op_valid && !flush;
   assign bad    = !is_legal(op_funct3, op_store) || is_misaligned(op_funct3, op_addr[1:0]);

   // Store steering uses the live op at accept; load extraction uses the latched offset.
   assign al_f3  = (state == IDLE) ? op_funct3    : f3_q;
   assign al_off = (state == IDLE) ? op_addr[1:0] : off_q;

   mem_align u_align (
      .funct3    (al_f3),
      .addr_lo   (al_off),
      .rs2       (op_wdata),
      .bus_rdata (bus_rdata),
      .wstrb     (al_wstrb),
      .wdata     (al_wdata),
      .ldata     (al_ldata)
   );

   // Upstream is held from the accept cycle until the response cycle.
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:      stall = op_valid && !flush;
         REQ, WAIT: stall = 1'b1;
         default:   stall = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: faulting ops skip the bus; flush only matters in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = bad ? RESP : REQ;
         REQ:  if (bus_gnt) state_nx = WAIT;
         WAIT: if (bus_rvalid) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Registered bus payload, response data, fault and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done      <= 1'b0;
         fault     <= 1'b0;
         rdata     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wstrb <= 4'b0000;
         bus_wdata <= '0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  f3_q  <= op_funct3;
                  off_q <= op_addr[1:0];
                  fault <= bad;
                  if (bad) begin
                     rdata <= '0;
                     done  <= 1'b1;
                  end else begin
                     bus_req   <= 1'b1;
                     bus_we    <= op_store;
                     bus_addr  <= {op_addr[XLEN-1:2], 2'b00};
                     bus_wstrb <= op_store ? al_wstrb : 4'b0000;
                     bus_wdata <= op_store ? al_wdata : '0;
                  end
               end
            end
            REQ: if (bus_gnt) bus_req <= 1'b0;
            WAIT: begin
               if (bus_rvalid) begin
                  done  <= 1'b1;
                  rdata <= bus_we ? '0 : al_ldata;
                  fault <= bus_err & BUS_ERR_EN;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-stage load/store unit directly downstream of the execute-stage adder/subtractor. It takes the effective address produced by add_sub (a + imm) together with store data and the access type. It runs one data-bus transaction per instruction over a req/gnt + rvalid handshake, steers byte lanes, and sign/zero-extends load data. It stalls the pipeline for the whole transaction.

Parameters:
XLEN, 32, datapath and address width; only 32 supported
BUS_ERR_EN, 1, 1 = bus_err is sampled with bus_rvalid; 0 = bus_err ignored

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op_valid  in  1  instruction in M stage is a memory op
op_store  in  1  1 = store, 0 = load
op_funct3  in  3  RV32 size/sign code
op_addr  in  32  effective address from add_sub q
op_wdata  in  32  store data (rs2)
flush  in  1  kill the op presented this cycle; IDLE only
stall  out  1  hold upstream stages
done  out  1  one-cycle completion pulse
rdata  out  32  formatted load result, valid with done
fault  out  1  misaligned/illegal/bus error, valid with done
bus_req  out  1  request, held until granted
bus_we  out  1  write enable
bus_addr  out  32  word-aligned address (op_addr[31:2], 2'b00)
bus_wstrb  out  4  byte strobes
bus_wdata  out  32  lane-steered store data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  response (load data or store ack)
bus_rdata  in  32  read data
bus_err  in  1  response error, qualified by bus_rvalid

Behaviour:
- Reset, async, immediate: state=IDLE; stall, done, fault, bus_req, bus_we = 0; bus_addr, bus_wstrb, bus_wdata, rdata = 0.
- All bus_* outputs and rdata/fault are registered. Upstream holds op_* stable while stall=1.
- stall = op_valid & ~flush in IDLE (combinational), or state in {REQ, WAIT}. stall=0 in RESP.
- funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE, op_valid & ~flush:
  - Illegal or misaligned: go to RESP with fault=1, rdata=0, no bus activity.
  - Otherwise: register bus_addr, bus_we, bus_wstrb, bus_wdata; bus_req=1; go to REQ.
- IDLE with flush=1 or op_valid=0: stay in IDLE.
- REQ: hold bus_req and payload until bus_gnt=1. On gnt: bus_req=0 next cycle, go to WAIT. bus_rvalid is never sampled in REQ, even in the grant cycle.
- WAIT: on bus_rvalid, capture the formatted load result (rdata=0 for stores) and fault = bus_err & BUS_ERR_EN; go to RESP. Otherwise wait indefinitely (no timeout).
- RESP: done=1 for exactly one cycle; go to IDLE. Ops are not accepted in RESP, so back-to-back ops are separated by one cycle.
- flush in REQ/WAIT is ignored; the bus transaction always completes.
- Minimum latency with gnt and rvalid one cycle apart: accept at cycle 0, REQ at 1 (gnt), WAIT at 2 (rvalid), done at cycle 3.
- Store lane steering:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111; wdata = rs2.
- Load extraction: select the byte/half at addr[1:0] (offset latched at accept), then sign- or zero-extend per funct3.
- rdata holds its value until the next done; fault is cleared on the next accept.

Decomposition:
- Package mem_pkg:
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP}
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - function is_misaligned(funct3, addr[1:0])
- Sub-module mem_align (combinational): given funct3, addr[1:0], rs2 and bus_rdata, produces wstrb, lane-steered wdata and extended load data.
- mem_lsu keeps only the FSM and registers.

Test Plan:
- LW at 0x1000, gnt at cycle 1, rvalid at cycle 2 with rdata=0xDEADBEEF -> bus_addr=0x1000, bus_we=0, done at cycle 3, rdata=0xDEADBEEF, fault=0, stall high for cycles 0-2.
- LB at 0x1003 with bus_rdata=0x80FF_0000 -> rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x2002 with rs2=0x1234ABCD -> bus_we=1, wstrb=1100, wdata=0xABCDABCD, done after ack, rdata=0.
- LW at 0x1001 -> no bus_req, done at cycle 1, fault=1. funct3=011 load -> same response.
- gnt delayed 5 cycles, with rvalid pulsed during REQ -> bus_req and payload held stable for 5 cycles, early rvalid ignored, completion only on rvalid in WAIT. flush asserted in WAIT -> ignored.
- rst asserted in WAIT -> outputs zero immediately, state IDLE; rvalid after reset release -> ignored. bus_err with rvalid on SW -> done with fault=1.
